// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and read-return owner encodings.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2,
    LOCK = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_owner_e;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter_age_ctr.sv
// Saturating wait counter: counts consecutive denied cycles of one requester.
module arb_age_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [WAIT_W-1:0] SAT_VAL = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != SAT_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == SAT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: cpu vs dbg, with aging,
// a bounded dbg lock and read-return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

  arb_state_e     r_state, w_nextState;
  logic [LCW-1:0] r_lockCnt, w_lockCntNext;
  logic           r_dbgBlock, w_dbgBlockNext;
  logic           r_rdPending;
  arb_owner_e     r_rdOwner;
  logic           w_cpuGnt, w_dbgGnt, w_dbgElig, w_locked;
  logic           w_cpuSat, w_dbgSat;

  arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_cpuAge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (cpu_req && !w_cpuGnt),
    .i_clr (!cpu_req || w_cpuGnt),
    .o_sat (w_cpuSat)
  );

  arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_dbgAge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (dbg_req && !w_dbgGnt),
    .i_clr (!dbg_req || w_dbgGnt),
    .o_sat (w_dbgSat)
  );

  assign w_locked = (r_state == LOCK) && dbg_lock;

  // Outside a lock cpu wins ties unless dbg has aged out; a force release bars dbg for one cycle.
  always_comb begin
    w_cpuGnt       = 1'b0;
    w_dbgGnt       = 1'b0;
    w_dbgElig      = 1'b0;
    w_nextState    = r_state;
    w_lockCntNext  = '0;
    w_dbgBlockNext = 1'b0;
    if (!rst_n) begin
      w_nextState = IDLE;
    end else if (w_locked) begin
      w_dbgGnt = dbg_req;
      if (r_lockCnt == LOCK_LAST) begin
        w_nextState    = IDLE;
        w_dbgBlockNext = 1'b1;
      end else begin
        w_nextState   = LOCK;
        w_lockCntNext = r_lockCnt + 1'b1;
      end
    end else begin
      w_dbgElig = dbg_req && !r_dbgBlock;
      if (cpu_req && (!w_dbgElig || !w_dbgSat || w_cpuSat)) begin
        w_cpuGnt = 1'b1;
      end else if (w_dbgElig) begin
        w_dbgGnt = 1'b1;
      end
      if (w_cpuGnt) begin
        w_nextState = CPU;
      end else if (w_dbgGnt) begin
        w_nextState = dbg_lock ? LOCK : DBG;
      end else if (r_state == LOCK) begin
        w_nextState = IDLE;
      end
    end
  end

  always_comb begin
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpuGnt) begin
      mem_r     = !cpu_we;
      mem_w     = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbgGnt) begin
      mem_r     = !dbg_we;
      mem_w     = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lockCnt   <= '0;
      r_dbgBlock  <= 1'b0;
      r_rdPending <= 1'b0;
      r_rdOwner   <= OWN_CPU;
    end else begin
      r_state     <= w_nextState;
      r_lockCnt   <= w_lockCntNext;
      r_dbgBlock  <= w_dbgBlockNext;
      r_rdPending <= (w_cpuGnt && !cpu_we) || (w_dbgGnt && !dbg_we);
      if (w_cpuGnt || w_dbgGnt) begin
        r_rdOwner <= w_cpuGnt ? OWN_CPU : OWN_DBG;
      end
    end
  end

  assign cpu_gnt    = w_cpuGnt;
  assign dbg_gnt    = w_dbgGnt;
  assign cpu_rvalid = r_rdPending && (r_rdOwner == OWN_CPU);
  assign dbg_rvalid = r_rdPending && (r_rdOwner == OWN_DBG);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data_mem and a read-return scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [31:0] rdata;
  logic        mem_r, mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          cyc;
    logic        owner;
    logic [31:0] data;
  } rdExp_t;

  rdExp_t      rdQueue[$];
  logic [31:0] dmem   [0:255];
  logic [31:0] refMem [0:255];
  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleCount  = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .rdata      (rdata),
    .mem_r      (mem_r),
    .mem_w      (mem_w),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural single-port data_mem: registered read, write wins
  always @(posedge clk) begin
    if (mem_w) dmem[mem_addr[7:0]] <= mem_wdata;
    else if (mem_r) mem_rdata <= dmem[mem_addr[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Read-return scoreboard: an entry granted in cycle N must come back in cycle N+1
  always @(negedge clk) begin
    logic        expRv;
    logic        expOwner;
    logic [31:0] expData;
    while (rdQueue.size() > 0 && rdQueue[0].cyc < cycleCount - 1) begin
      checkOutput("missedRvalid", 32'd1, 32'd0);
      void'(rdQueue.pop_front());
    end
    expRv    = (rdQueue.size() > 0) && (rdQueue[0].cyc == cycleCount - 1);
    expOwner = expRv ? rdQueue[0].owner : 1'b0;
    expData  = expRv ? rdQueue[0].data : 32'd0;
    checkOutput("cpuRvalid", {31'd0, cpu_rvalid}, {31'd0, expRv && !expOwner});
    checkOutput("dbgRvalid", {31'd0, dbg_rvalid}, {31'd0, expRv && expOwner});
    if (expRv) begin
      checkOutput("rdata", rdata, expData);
      void'(rdQueue.pop_front());
    end
  end

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic dLock, input logic eCpu, input logic eDbg);
    logic        eWe;
    logic [31:0] eAddr, eWdata;
    rdExp_t      item;
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
    dbg_req = dReq; dbg_we = dWe; dbg_addr = dAddr; dbg_wdata = dWdata; dbg_lock = dLock;
    @(negedge clk);
    eWe    = eCpu ? cWe : dWe;
    eAddr  = eCpu ? cAddr : (eDbg ? dAddr : 32'd0);
    eWdata = eCpu ? cWdata : (eDbg ? dWdata : 32'd0);
    checkOutput("cpuGnt", {31'd0, cpu_gnt}, {31'd0, eCpu});
    checkOutput("dbgGnt", {31'd0, dbg_gnt}, {31'd0, eDbg});
    checkOutput("memR", {31'd0, mem_r}, {31'd0, (eCpu || eDbg) && !eWe});
    checkOutput("memW", {31'd0, mem_w}, {31'd0, (eCpu || eDbg) && eWe});
    checkOutput("memAddr", mem_addr, eAddr);
    checkOutput("memWdata", mem_wdata, eWdata);
    if (eCpu || eDbg) begin
      if (eWe) begin
        refMem[eAddr[7:0]] = eWdata;
      end else begin
        item.cyc   = cycleCount;
        item.owner = eDbg && !eCpu;
        item.data  = refMem[eAddr[7:0]];
        rdQueue.push_back(item);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpuGnt"}, {31'd0, cpu_gnt}, 32'd0);
    checkOutput({tag, "_dbgGnt"}, {31'd0, dbg_gnt}, 32'd0);
    checkOutput({tag, "_cpuRvalid"}, {31'd0, cpu_rvalid}, 32'd0);
    checkOutput({tag, "_dbgRvalid"}, {31'd0, dbg_rvalid}, 32'd0);
    checkOutput({tag, "_memR"}, {31'd0, mem_r}, 32'd0);
    checkOutput({tag, "_memW"}, {31'd0, mem_w}, 32'd0);
    checkOutput({tag, "_memAddr"}, mem_addr, 32'd0);
    checkOutput({tag, "_memWdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]   = 32'd0;
      refMem[i] = 32'd0;
    end
    dmem[2] = 32'd31;   refMem[2] = 32'd31;
    dmem[3] = 32'd1024; refMem[3] = 32'd1024;
    dmem[4] = 32'd9;    refMem[4] = 32'd9;
    dmem[5] = 32'd2040; refMem[5] = 32'd2040;
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    #2;
    checkAllZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single cpu read");
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();

    $display("[TB] contention with dbg aging");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 3, 0, 1, 1, 6, 55, 0, 1, 0);
    applyStimulus(1, 0, 3, 0, 1, 1, 6, 55, 0, 0, 1);
    idleCycle();
    applyStimulus(1, 0, 6, 0, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();

    $display("[TB] back-to-back dbg reads");
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1);
    idleCycle();

    $display("[TB] dbg lock with force release");
    applyStimulus(0, 0, 0, 0, 1, 0, 4, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 2, 0, 1, 0, 4, 0, 1, 0, 1);
    applyStimulus(1, 0, 2, 0, 1, 0, 4, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1);
    idleCycle();

    $display("[TB] reset during pending read");
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    cpu_req = 0; cpu_addr = 0;
    rst_n = 1'b0;
    rdQueue.delete();
    #1;
    checkAllZero("midReset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();

    $display("[TB] simultaneous writes to one address");
    applyStimulus(1, 1, 2, 77, 1, 1, 2, 88, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 88, 0, 0, 1);
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    idleCycle();
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
